// File: rtl/ahb_display.sv
// ahb_display
//   AHB-Lite write/read slave driving a multiplexed, active-low seven-segment
//   display. DATA writes land in a pending buffer and are copied into the
//   displayed (shadow) buffer only at a frame boundary, so a frame never
//   mixes old and new digits.
//
//   Optional feature macro: DISPLAY_BLINK_EN (frame counter + CTRL.BLINK).
//
//   Ports
//     HCLK, HRESETn       clock, synchronous active-low reset
//     HADDR[3:2]          register select (DATA, CTRL, STATUS, reserved)
//     HWDATA/HRDATA       data-phase write/read data
//     HSIZE               ignored, every access is treated as a word
//     HTRANS/HWRITE/HREADY/HSEL   AHB-Lite address-phase controls
//     HREADYOUT           always 1, zero wait states
//     nDigit[DIGITS-1:0]  digit enables, active-low, at most one low
//     nSegment[7:0]       a..g = bits 0..6, dp = bit 7, active-low
module ahb_display #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [31:0]       HADDR,
   input  logic [31:0]       HWDATA,
   input  logic [2:0]        HSIZE,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic              HREADY,
   input  logic              HSEL,
   output logic [31:0]       HRDATA,
   output logic              HREADYOUT,
   output logic [DIGITS-1:0] nDigit,
   output logic [7:0]        nSegment
);

   localparam int          PW        = $clog2(SCAN_DIV);
   localparam logic [31:0] DATA_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << (4*DIGITS)) - 32'd1);
   localparam logic [2:0]  LAST_IDX  = 3'(DIGITS-1);

   logic          write_enable, read_enable;
   logic [1:0]    word_address;
   logic [31:0]   pending, shadow;   // bits above 4*DIGITS stay zero
   logic          pend;
   logic          en;
   logic          blink_bit;
   logic          blink_off;
   logic [7:0]    dp_mask, blank_mask;
   logic [PW-1:0] presc;
   logic [2:0]    idx;
   logic          tc, frame_bnd, data_wr, ctrl_wr;
   logic [3:0]    nib;
   logic [6:0]    seg;

   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

   assign HREADYOUT = 1'b1;
   assign tc        = (presc == PW'(SCAN_DIV-1));
   assign frame_bnd = tc && (idx == LAST_IDX);
   assign data_wr   = write_enable && (word_address == 2'd0);
   assign ctrl_wr   = write_enable && (word_address == 2'd1);

   // Address phase capture
   always_ff @(posedge HCLK) begin
      if (!HRESETn || !(HREADY && HSEL && HTRANS != 2'b00)) begin
         write_enable <= 1'b0;
         read_enable  <= 1'b0;
         word_address <= 2'd0;
      end else begin
         write_enable <= HWRITE;
         read_enable  <= !HWRITE;
         word_address <= HADDR[3:2];
      end
   end

   // Refresh prescaler and digit index
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         presc <= '0;
         idx   <= 3'd0;
      end else if (tc) begin
         presc <= '0;
         idx   <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Double buffer. A write coinciding with a boundary still lets the old
   // pending value through to shadow, and keeps PEND set for the new one.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pending <= 32'd0;
         shadow  <= 32'd0;
         pend    <= 1'b0;
      end else begin
         if (frame_bnd && pend)
            shadow <= pending;
         if (data_wr) begin
            pending <= HWDATA & DATA_MASK;
            pend    <= 1'b1;
         end else if (frame_bnd) begin
            pend    <= 1'b0;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         en         <= 1'b0;
         dp_mask    <= 8'd0;
         blank_mask <= 8'd0;
      end else if (ctrl_wr) begin
         en         <= HWDATA[0];
         dp_mask    <= HWDATA[15:8];
         blank_mask <= HWDATA[23:16];
      end
   end

`ifdef DISPLAY_BLINK_EN
   logic [7:0] frame_cnt;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         blink_bit <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         if (ctrl_wr)
            blink_bit <= HWDATA[1];
         if (frame_bnd)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // 32 frames on, 32 frames off
   assign blink_off = blink_bit && frame_cnt[5];
`else
   assign blink_bit = 1'b0;
   assign blink_off = 1'b0;
`endif

   // Data-phase read mux; zero whenever no read is in its data phase
   always_comb begin
      HRDATA = 32'd0;
      if (read_enable) begin
         case (word_address)
            2'd0:    HRDATA = pending;
            2'd1:    HRDATA = {8'd0, blank_mask, dp_mask, 6'd0, blink_bit, en};
            2'd2:    HRDATA = {21'd0, idx, 7'd0, pend};
            default: HRDATA = 32'd0;
         endcase
      end
   end

   assign nib = shadow[{idx, 2'b00} +: 4];

   // Active-high abcdefg
   always_comb begin
      seg = 7'h00;
      case (nib)
         4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

   // Registered display drive
   always_ff @(posedge HCLK) begin
      if (!HRESETn || !en || blank_mask[idx] || blink_off) begin
         nDigit   <= '1;
         nSegment <= 8'hFF;
      end else begin
         nDigit   <= ~(DIGITS'(1) << idx);
         nSegment <= {~dp_mask[idx], ~seg};
      end
   end

endmodule

// File: tb/tb_ahb_display.sv
module tb_ahb_display;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b0;
   logic [31:0] HADDR   = 32'd0;
   logic [31:0] HWDATA  = 32'd0;
   logic [2:0]  HSIZE   = 3'b010;
   logic [1:0]  HTRANS  = 2'b00;
   logic        HWRITE  = 1'b0;
   logic        HREADY  = 1'b1;
   logic        HSEL    = 1'b0;
   wire  [31:0] HRDATA;
   wire         HREADYOUT;
   wire  [3:0]  nDigit;
   wire  [7:0]  nSegment;

   int checks = 0;
   int errors = 0;
   int t = 0;   // clock edges since the last reset edge

   ahb_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
      .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .nDigit(nDigit), .nSegment(nSegment)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) begin
      if (!HRESETn) t <= 0;
      else          t <= t + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      step();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      step();
   endtask

   task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      step();
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
      step();
   endtask

   // Returns at the first negedge of a digit-0 slot
   task automatic sync_frame(input string tag);
      logic [3:0] prev;
      bit found;
      found = 1'b0;
      prev  = nDigit;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge HCLK);
         if (nDigit == 4'b1110 && prev != 4'b1110) found = 1'b1;
         prev = nDigit;
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   // segs: expected nSegment per digit, digit 0 in the low byte
   task automatic check_frame(input string tag, input logic [31:0] segs);
      logic [3:0] ed;
      sync_frame({tag, "_sync"});
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge HCLK);
         ed = ~(4'b0001 << (k / 4));
         chk({tag, "_frame"}, {nDigit, nSegment}, {ed, segs[8*(k/4) +: 8]});
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  ed;
      logic [7:0]  es;
      int fr, dig;
      bit dark, blink_on;
`ifdef DISPLAY_BLINK_EN
      blink_on = 1'b1;
`else
      blink_on = 1'b0;
`endif

      // Reset and idle
      repeat (3) @(posedge HCLK);
      #1;
      chk("reset_state", {nDigit, nSegment, HRDATA, HREADYOUT}, {4'hF, 8'hFF, 32'h0, 1'b1});
      HRESETn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge HCLK);
         chk("idle_dark", {nDigit, nSegment, HRDATA, HREADYOUT}, {4'hF, 8'hFF, 32'h0, 1'b1});
      end
      step();

      // Register access basics
      ahb_write(32'h4, 32'h0000_0001);
      ahb_read(32'h4, rd);
      chk("ctrl_rd", rd, 32'h1);
      HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h0;   // idle transfer
      step();
      HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'hAAAA;
      step();
      ahb_read(32'h0, rd);
      chk("idle_no_write", rd, 32'h0);
      ahb_write(32'h8, 32'hFFFF_FFFF);
      ahb_read(32'h8, rd);
      chk("status_ro", rd & ~32'h700, 32'h0);
      ahb_write(32'hC, 32'hFFFF_FFFF);
      ahb_read(32'hC, rd);
      chk("reserved_rd", rd, 32'h0);

      // DATA write, PEND until the boundary, then scan sequence
      sync_frame("s1");
      step();
      ahb_write(32'h0, 32'h0000_8F10);
      ahb_read(32'h8, rd);
      chk("status_pend", rd, 32'h0000_0101);
      check_frame("f8F10", 32'h808E_F9C0);
      step();
      ahb_read(32'h8, rd);
      chk("status_clear", rd, 32'h0);

      // DATA write exactly on the frame-boundary edge
      sync_frame("s2");
      step();
      ahb_write(32'h0, 32'h0000_5678);
      repeat (10) step();
      ahb_write(32'h0, 32'h0000_1234);
      ahb_read(32'h8, rd);
      chk("collide_pend", rd, 32'h1);
      chk("collide_d0", {nDigit, nSegment}, {4'hE, 8'h80});
      ahb_read(32'h0, rd);
      chk("collide_pending", rd, 32'h1234);
      repeat (9) step();
      chk("collide_d3", {nDigit, nSegment}, {4'h7, 8'h92});
      check_frame("f1234", 32'hF9A4_B099);
      step();
      ahb_read(32'h8, rd);
      chk("collide_clear", rd, 32'h0);

      // DP on digit 0, digit 1 blanked
      ahb_write(32'h4, 32'h0002_0101);
      ahb_read(32'h4, rd);
      chk("ctrl_dp_rd", rd, 32'h0002_0101);
      sync_frame("s3");
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge HCLK);
         case (k / 4)
            0:       begin ed = 4'hE; es = 8'h19; end
            1:       begin ed = 4'hF; es = 8'hFF; end
            default: begin ed = 4'hB; es = 8'hA4; end
         endcase
         chk("dp_blank", {nDigit, nSegment}, {ed, es});
      end

      // One-cycle reset while index 2 is scanning
      HRESETn = 1'b0;
      step();
      HRESETn = 1'b1;
      chk("rst_dark", {nDigit, nSegment}, {4'hF, 8'hFF});
      ahb_read(32'h8, rd);
      chk("rst_status", rd, 32'h0);
      ahb_read(32'h4, rd);
      chk("rst_ctrl", rd, 32'h0);
      ahb_read(32'h0, rd);
      chk("rst_data", rd, 32'h0);

      // Blink
      ahb_write(32'h4, 32'h0000_0003);
      ahb_read(32'h4, rd);
      chk("blink_ctrl_rd", rd, blink_on ? 32'h3 : 32'h1);
      while (t < 17) @(negedge HCLK);
      while (t <= 96*16) begin
         fr   = (t - 1) / 16;
         dig  = ((t - 1) % 16) / 4;
         dark = blink_on && fr >= 32 && fr < 64;
         ed   = dark ? 4'hF : ~(4'b0001 << dig);
         es   = dark ? 8'hFF : 8'hC0;
         chk("blink", {nDigit, nSegment}, {ed, es});
         @(negedge HCLK);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
